// File: rtl/mem_arbiter.sv
// Three-way memory port arbiter (dcache / icache / prefetch) with prefetch
// starvation boost and a tag-ownership table that routes returning loads.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dc_command,
  input  logic [`XLEN-1:0]  dc_addr,
  input  logic [63:0]       dc_data,
  input  logic [1:0]        ic_command,
  input  logic [`XLEN-1:0]  ic_addr,
  input  logic [1:0]        pf_command,
  input  logic [`XLEN-1:0]  pf_addr,
  input  logic              flush,
  input  logic [3:0]        mem2proc_response,
  input  logic [3:0]        mem2proc_tag,
  input  logic [63:0]       mem2proc_data,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  output logic [3:0]        dc_response,
  output logic [3:0]        ic_response,
  output logic [3:0]        pf_response,
  output logic [3:0]        dc_tag,
  output logic [3:0]        ic_tag,
  output logic [3:0]        pf_tag,
  output logic [63:0]       rsp_data,
  output logic              pf_starved
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DC   = 2'd1;
  localparam logic [1:0] OWN_IC   = 2'd2;
  localparam logic [1:0] OWN_PF   = 2'd3;

  typedef enum logic {ST_NORMAL, ST_BOOST} state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [15:1][1:0]  owner_q, owner_d;

  logic       dc_req, ic_req, pf_req;
  logic [1:0] gnt, ret_own;
  logic       accepted, pf_ok, pf_refused, load_ok;

  assign dc_req = (dc_command == BUS_LOAD) || (dc_command == BUS_STORE);
  assign ic_req = (ic_command != BUS_NONE);
  assign pf_req = (pf_command == BUS_LOAD);

  // dcache always wins; boost only swaps icache and prefetch
  always_comb begin
    gnt = OWN_NONE;
    if (dc_req)                  gnt = OWN_DC;
    else if (state_q == ST_BOOST) begin
      if (pf_req)                gnt = OWN_PF;
      else if (ic_req)           gnt = OWN_IC;
    end else begin
      if (ic_req)                gnt = OWN_IC;
      else if (pf_req)           gnt = OWN_PF;
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    case (gnt)
      OWN_DC: begin
        proc2mem_command = dc_command;
        proc2mem_addr    = dc_addr;
        proc2mem_data    = dc_data;
      end
      OWN_IC: begin
        proc2mem_command = ic_command;
        proc2mem_addr    = ic_addr;
      end
      OWN_PF: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = pf_addr;
      end
      default: ;
    endcase
  end

  assign dc_response = (gnt == OWN_DC) ? mem2proc_response : 4'd0;
  assign ic_response = (gnt == OWN_IC) ? mem2proc_response : 4'd0;
  assign pf_response = (gnt == OWN_PF) ? mem2proc_response : 4'd0;

  assign accepted   = (gnt != OWN_NONE) && (mem2proc_response != 4'd0);
  assign pf_ok      = (gnt == OWN_PF) && accepted;
  assign pf_refused = pf_req && !pf_ok;
  assign load_ok    = accepted && (proc2mem_command == BUS_LOAD);

  always_comb begin
    ret_own = OWN_NONE;
    for (int i = 1; i <= 15; i++)
      if (mem2proc_tag == 4'(i)) ret_own = owner_q[i];
  end

  // Routing is suppressed in reset so pre-reset returns reach nobody
  assign dc_tag   = (reset && ret_own == OWN_DC) ? mem2proc_tag : 4'd0;
  assign ic_tag   = (reset && ret_own == OWN_IC) ? mem2proc_tag : 4'd0;
  assign pf_tag   = (reset && ret_own == OWN_PF) ? mem2proc_tag : 4'd0;
  assign rsp_data = mem2proc_data;

  always_comb begin
    if (pf_ok)                               starve_d = 4'd0;
    else if (pf_refused && starve_q != 4'hF) starve_d = starve_q + 4'd1;
    else                                     starve_d = starve_q;
  end

  // Clear order: flush, then retiring tag, then new allocation (write wins)
  always_comb begin
    owner_d = owner_q;
    for (int i = 1; i <= 15; i++) begin
      if (flush && owner_q[i] == OWN_PF)  owner_d[i] = OWN_NONE;
      if (mem2proc_tag == 4'(i))          owner_d[i] = OWN_NONE;
      if (load_ok && mem2proc_response == 4'(i))
        owner_d[i] = (flush && gnt == OWN_PF) ? OWN_NONE : gnt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q <= '0;
      owner_q  <= '0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_NORMAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (!flush && pf_refused && starve_d >= LIMIT) state_d = ST_BOOST;
      ST_BOOST:  if (pf_ok || flush || !pf_req)                 state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    pf_starved = reset && (state_q == ST_BOOST);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive refused prefetch cycles before prefetch is promoted.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports dc_command/dc_addr/dc_data  in  2/`XLEN/64  dcache request (BUS_NONE/BUS_LOAD/BUS_STORE), address, store data.
REQ-005 SHALL have ports ic_command/ic_addr  in  2/`XLEN  icache demand fetch request.
REQ-006 SHALL have ports pf_command/pf_addr  in  2/`XLEN  prefetcher request (loads only; BUS_STORE treated as BUS_NONE).
REQ-007 SHALL have port flush  in  1  branch redirect; orphans outstanding prefetch loads.
REQ-008 SHALL have ports mem2proc_response/mem2proc_tag/mem2proc_data  in  4/4/64  memory accept tag (0 = refused), returning tag, return data.
REQ-009 SHALL have ports proc2mem_command/proc2mem_addr/proc2mem_data  out  2/`XLEN/64  request driven to memory.
REQ-010 SHALL have ports dc_response/ic_response/pf_response  out  4 each  mem2proc_response routed to granted requester, 0 otherwise.
REQ-011 SHALL have ports dc_tag/ic_tag/pf_tag  out  4 each  mem2proc_tag routed to owning requester, 0 otherwise; mem2proc_data fanned out unchanged on rsp_data.
REQ-012 SHALL have port pf_starved  out  1  promotion state active.

Function
REQ-013 SHALL grant at most one requester per cycle; grant and proc2mem_* outputs combinational from current inputs and state.
REQ-014 SHALL use fixed priority dcache > icache > prefetch in state NORMAL.
REQ-015 SHALL use priority dcache > prefetch > icache in state BOOST.
REQ-016 SHALL drive proc2mem_command = BUS_NONE, addr = 0, data = 0 when no request is granted.
REQ-017 SHALL count starve_cnt (4 bits, saturating at 15) on cycles pf requests and is not accepted (not granted, or granted with response 0); clear on accepted prefetch.
REQ-018 SHALL transition NORMAL -> BOOST at the clock edge where starve_cnt reaches STARVE_LIMIT; BOOST -> NORMAL on accepted prefetch, on flush, or when pf_command = BUS_NONE.
REQ-019 SHALL maintain a 15-entry owner table indexed by tag 1..15, 2-bit entries: NONE, DC, IC, PF.
REQ-020 SHALL write owner[mem2proc_response] = granted requester on the edge following an accepted BUS_LOAD; accepted BUS_STORE writes nothing.
REQ-021 SHALL, when mem2proc_tag != 0, drive the owner's *_tag = mem2proc_tag in the same cycle and set that entry NONE at the edge; owner NONE routes to nobody.
REQ-022 SHALL, when the returning tag equals the newly accepted tag in one cycle, route the return by the old entry, then store the new owner (write wins).
REQ-023 SHALL, on flush, set every PF entry NONE at the edge; a PF tag returning in the flush cycle is still routed to prefetch; a prefetch accepted in the flush cycle is recorded NONE.
REQ-024 SHALL ignore mem2proc_response for requesters not granted; mem2proc_response = 0 creates no table entry.
REQ-025 SHALL hold all state on cycles with no request and no return.

Reset
REQ-026 SHALL, while reset = 0 at a clock edge, clear owner table to NONE, starve_cnt to 0, state to NORMAL.
REQ-027 SHALL drive, during reset, pf_starved = 0 and all *_tag = 0; proc2mem_* and *_response remain combinational per REQ-013..016.
REQ-028 SHALL discard routing of loads outstanding across reset: their returns route to nobody.

Verification
REQ-029 SHALL pass: dc BUS_LOAD 0x100 + ic BUS_LOAD 0x200 same cycle, response 3 -> proc2mem_addr 0x100, dc_response 3, ic_response 0; tag 3 later -> dc_tag 3 only.
REQ-030 SHALL pass: pf requests 8 cycles, always refused by ic -> pf_starved 1 on 9th cycle; pf+ic request, response 5 -> pf_response 5; next cycle pf_starved 0.
REQ-031 SHALL pass: pf load accepted tag 7, flush, tag 7 returns -> pf_tag 0, ic_tag 0, dc_tag 0.
REQ-032 SHALL pass: ic load accepted tag 2 while mem2proc_tag 2 returns for prior dc load -> dc_tag 2 that cycle; later tag 2 -> ic_tag 2.
REQ-033 SHALL pass: dc BUS_STORE accepted tag 4, tag 4 returns -> all *_tag 0.
REQ-034 SHALL pass: ic load accepted tag 9, reset = 0 one cycle, tag 9 returns -> ic_tag 0, pf_starved 0.
